apb_timer_mc: RTL and testbench
===============================

Name: apb_timer_mc

Overview:
- Multi-channel, parametrised successor of the single-channel 8-bit APB timer.
- NUM_CH independent CNT_W-bit up/down counters. Each channel has an auto-reload data register, a control register, a status register and a readable count register.
- Shared prescaler.
- Sits on the peripheral APB bus beside the CPU bus-functional master; drives one interrupt line per channel to the interrupt controller.

Parameters:
- NUM_CH, 4, number of timer channels (1..64).
- CNT_W, 8, counter, TDR and APB data width (8..32).

Ports:
- pclk  input  1  APB clock; all logic on rising edge.
- presetn  input  1  synchronous active-low reset.
- psel  input  1  APB select.
- penable  input  1  APB access phase.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  8  byte address; [7:2] = channel, [1:0] = register.
- pwdata  input  CNT_W  write data.
- prdata  output  CNT_W  read data, registered.
- pready  output  1  transfer complete.
- pslverr  output  1  transfer error.
- irq  output  NUM_CH  per-channel interrupt, level.

Behaviour:
- Reset (presetn low at pclk edge): all TDR/TCR/TSR/TCNT = 0, prescaler = 0, prdata = 0, pready = 0, pslverr = 0, irq = 0. Reset mid-transfer aborts it; no register update.
- APB timing:
  - One wait state: in the first access cycle (psel & penable & !pready), pready <= 1. The next cycle completes the transfer, and pready returns to 0 after it.
  - Write commits, and prdata is loaded, on the same edge that raises pready.
  - Transfer without psel is ignored.
- Register map per channel (offset):
  - 0 TDR: R/W, reload value.
  - 1 TCR: R/W, 8 bits zero-extended:
    - [0] EN
    - [1] DOWN
    - [3:2] CKS: 00 = /2, 01 = /4, 10 = /8, 11 = /16
    - [4] OVF_IE
    - [5] UDF_IE
    - [7] LOAD: write-only, reads 0
    - [6] reserved, reads 0
  - 2 TSR: [0] OVF, [1] UDF; write-1-to-clear; other bits read 0.
  - 3 TCNT: read-only current count; writes ignored.
- Prescaler:
  - Free-running 4-bit counter, increments every cycle.
  - tick_k asserted when prescaler[k:0] is all ones, where k = CKS.
- Counting: when EN = 1 and the channel tick is asserted:
  - DOWN = 0: TCNT + 1.
  - DOWN = 0, TCNT = all ones: TCNT <= TDR, OVF <= 1.
  - DOWN = 1: TCNT - 1.
  - DOWN = 1, TCNT = 0: TCNT <= TDR, UDF <= 1.
  - EN = 0: TCNT holds.
- LOAD: a TCR write with bit 7 = 1 copies TDR (value before this write) into TCNT on the commit edge.
  - Load overrides a same-cycle tick; no flag set.
  - The other TCR bits are written normally.
- Flag priority: hardware set beats a same-cycle write-1-clear.
- TDR write does not affect TCNT until the next LOAD or reload.
- irq[ch] = (OVF & OVF_IE) | (UDF & UDF_IE), registered from flag state.
- Channel address >= NUM_CH: write ignored, read returns 0.

Optional Feature:
- APB_TIMER_MC_PSLVERR_EN
- Defined: pslverr = 1 together with pready for:
  - any access to channel >= NUM_CH;
  - a write to TCNT.
  - No state change on an errored access.
- Undefined: pslverr tied 0; the same accesses are silently ignored or return 0.

Decomposition:
- Package apb_timer_mc_pkg:
  - register offset constants (TDR_OFS, TCR_OFS, TSR_OFS, TCNT_OFS);
  - TCR/TSR bit index constants;
  - CKS encoding constants.
- Sub-module timer_mc_channel, one per channel, instantiated with generate. It holds TDR/TCR/TSR/TCNT and count/reload/flag logic, takes tick vector and decoded write strobes, and returns read data and irq.
- The top keeps the APB FSM, address decode, prescaler and read mux.

Test Plan:
- Reset → reads of every register in every channel return 0; pready high exactly one cycle per transfer, two cycles after psel.
- 20 random writes/reads to TDR of ch0..ch3 (addr 0x00/0x04/0x08/0x0C) → rdata equals wdata; TCR bit 7 reads 0.
- ch1: TDR = 8'hFD, TCR = 8'h91 (LOAD, OVF_IE, EN, up, /2) → TCNT goes FD, FE, FF, then FD; OVF = 1, irq[1] = 1 after 6 cycles; write TSR = 1 → OVF and irq[1] clear.
- ch2: TDR = 8'h02, TCR = 8'hA7 (LOAD, UDF_IE, CKS = 01, DOWN, EN) → decrements every 4 cycles; on 0 reloads to 02 and UDF = 1; OVF stays 0.
- Simultaneous: W1C to TSR on the same edge as an overflow → flag remains 1. LOAD on a tick edge → TCNT = TDR, no flag.
- With APB_TIMER_MC_PSLVERR_EN: read addr 0x10 (NUM_CH = 4) and write TCNT → pslverr = 1 with pready, prdata = 0, TCNT unchanged. Without the macro: pslverr = 0.

Source files
------------

// File: rtl/apb_timer_mc_pkg.sv
// Shared definitions for the multi-channel APB timer.
// Contents: register offsets, TCR/TSR bit positions, CKS encodings and the APB
// handshake state type. Used by apb_timer_mc and timer_mc_channel.
package apb_timer_mc_pkg;

  // Register offsets within a channel (paddr[1:0])
  localparam logic [1:0] TDR_OFS  = 2'd0;
  localparam logic [1:0] TCR_OFS  = 2'd1;
  localparam logic [1:0] TSR_OFS  = 2'd2;
  localparam logic [1:0] TCNT_OFS = 2'd3;

  // TCR bit positions
  localparam int unsigned TCR_EN     = 0;
  localparam int unsigned TCR_DOWN   = 1;
  localparam int unsigned TCR_CKS_LO = 2;
  localparam int unsigned TCR_CKS_HI = 3;
  localparam int unsigned TCR_OVF_IE = 4;
  localparam int unsigned TCR_UDF_IE = 5;
  localparam int unsigned TCR_LOAD   = 7;

  // Only TCR[5:0] are storage; [6] is reserved and [7] is a write-only strobe
  localparam int unsigned TcrStoredW = 6;

  // TSR bit positions
  localparam int unsigned TSR_OVF = 0;
  localparam int unsigned TSR_UDF = 1;

  // CKS encodings (prescaler divide ratio)
  localparam logic [1:0] CKS_DIV2  = 2'b00;
  localparam logic [1:0] CKS_DIV4  = 2'b01;
  localparam logic [1:0] CKS_DIV8  = 2'b10;
  localparam logic [1:0] CKS_DIV16 = 2'b11;

  // APB handshake: StDone is the single cycle in which pready is high
  typedef enum logic [0:0] {
    StIdle,
    StDone
  } apb_state_e;

endpackage

// File: rtl/timer_mc_channel.sv
// One timer channel: TDR (reload), TCR (control), TSR (flags) and TCNT (count).
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   tick_i[3:0]            prescaler ticks for /2, /4, /8, /16
//   we_tdr_i/we_tcr_i/we_tsr_i  decoded write strobes, asserted on the commit edge
//   wdata_i                write data
//   reg_sel_i              register offset for the read mux
//   rdata_o                read data for reg_sel_i (combinational)
//   irq_o                  registered interrupt level
module timer_mc_channel
  import apb_timer_mc_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [3:0]       tick_i,
  input  logic             we_tdr_i,
  input  logic             we_tcr_i,
  input  logic             we_tsr_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic [1:0]       reg_sel_i,
  output logic [CNT_W-1:0] rdata_o,
  output logic             irq_o
);

  logic [CNT_W-1:0]      tdr_q, tdr_d;
  logic [CNT_W-1:0]      tcnt_q, tcnt_d;
  logic [TcrStoredW-1:0] tcr_q, tcr_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  irq_q, irq_d;

  logic tick;
  logic load;
  logic ovf_set;
  logic udf_set;

  always_comb begin
    tick    = tick_i[tcr_q[TCR_CKS_HI:TCR_CKS_LO]];
    load    = we_tcr_i & wdata_i[TCR_LOAD];
    ovf_set = 1'b0;
    udf_set = 1'b0;
    tcnt_d  = tcnt_q;

    // LOAD uses the pre-write TDR and wins over a coincident tick
    if (load) begin
      tcnt_d = tdr_q;
    end else if (tcr_q[TCR_EN] && tick) begin
      if (!tcr_q[TCR_DOWN]) begin
        if (tcnt_q == '1) begin
          tcnt_d  = tdr_q;
          ovf_set = 1'b1;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end else begin
        if (tcnt_q == '0) begin
          tcnt_d  = tdr_q;
          udf_set = 1'b1;
        end else begin
          tcnt_d = tcnt_q - CNT_W'(1);
        end
      end
    end

    tdr_d = we_tdr_i ? wdata_i : tdr_q;
    tcr_d = we_tcr_i ? wdata_i[TcrStoredW-1:0] : tcr_q;

    // Hardware set has priority over write-1-to-clear
    ovf_d = ovf_set | (ovf_q & ~(we_tsr_i & wdata_i[TSR_OVF]));
    udf_d = udf_set | (udf_q & ~(we_tsr_i & wdata_i[TSR_UDF]));

    irq_d = (ovf_q & tcr_q[TCR_OVF_IE]) | (udf_q & tcr_q[TCR_UDF_IE]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tdr_q  <= '0;
      tcnt_q <= '0;
      tcr_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      tdr_q  <= tdr_d;
      tcnt_q <= tcnt_d;
      tcr_q  <= tcr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    unique case (reg_sel_i)
      TDR_OFS:  rdata_o = tdr_q;
      TCR_OFS:  rdata_o = CNT_W'(tcr_q);
      TSR_OFS:  rdata_o = CNT_W'({udf_q, ovf_q});
      TCNT_OFS: rdata_o = tcnt_q;
      default:  rdata_o = '0;
    endcase
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer: NUM_CH up/down counters sharing a 4-bit prescaler.
// Ports:
//   pclk, presetn        APB clock, synchronous active-low reset
//   psel, penable, pwrite, paddr, pwdata   APB request; paddr[7:2] channel, [1:0] register
//   prdata               registered read data
//   pready               high for one cycle, one wait state after the access phase starts
//   pslverr              transfer error (only with APB_TIMER_MC_PSLVERR_EN defined)
//   irq[NUM_CH-1:0]      per-channel interrupt level
// Optional: define APB_TIMER_MC_PSLVERR_EN to flag accesses to absent channels and
// writes to TCNT; otherwise those accesses are silently ignored / read 0.
module apb_timer_mc
  import apb_timer_mc_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [7:0]        paddr,
  input  logic [CNT_W-1:0]  pwdata,
  output logic [CNT_W-1:0]  prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] irq
);

  apb_state_e       state_q, state_d;
  logic [CNT_W-1:0] prdata_q, prdata_d;
  logic             pslverr_q, pslverr_d;
  logic [3:0]       presc_q, presc_d;
  logic [3:0]       tick;

  logic [5:0]       ch_idx;
  logic [1:0]       reg_sel;
  logic             ch_valid;
  logic             access;
  logic             err;
  logic             wr_ok;
  logic [CNT_W-1:0] rd_mux;
  logic [CNT_W-1:0] ch_rdata [NUM_CH];

  assign ch_idx   = paddr[7:2];
  assign reg_sel  = paddr[1:0];
  assign ch_valid = (32'(ch_idx) < NUM_CH);

  // First access-phase cycle; pready is low here, so this fires once per transfer
  assign access = (state_q == StIdle) & psel & penable;

`ifdef APB_TIMER_MC_PSLVERR_EN
  assign err = ~ch_valid | (pwrite & (reg_sel == TCNT_OFS));
`else
  assign err = 1'b0;
`endif

  assign wr_ok = access & pwrite & ch_valid & ~err;

  // Prescaler ticks: tick[k] when presc_q[k:0] is all ones
  always_comb begin
    presc_d = presc_q + 4'd1;
    tick[0] = presc_q[0];
    tick[1] = &presc_q[1:0];
    tick[2] = &presc_q[2:0];
    tick[3] = &presc_q[3:0];
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(ch_idx) == i) begin
        rd_mux = ch_rdata[i];
      end
    end
    if (err || !ch_valid) begin
      rd_mux = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    prdata_d  = prdata_q;
    pslverr_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          state_d   = StDone;
          pslverr_d = err;
          if (!pwrite) begin
            prdata_d = rd_mux;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q   <= StIdle;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      presc_q   <= '0;
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      presc_q   <= presc_d;
    end
  end

  assign pready  = (state_q == StDone);
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we_tdr, we_tcr, we_tsr;

    assign we_tdr = wr_ok & (ch_idx == 6'(i)) & (reg_sel == TDR_OFS);
    assign we_tcr = wr_ok & (ch_idx == 6'(i)) & (reg_sel == TCR_OFS);
    assign we_tsr = wr_ok & (ch_idx == 6'(i)) & (reg_sel == TSR_OFS);

    timer_mc_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i     (pclk),
      .rst_ni    (presetn),
      .tick_i    (tick),
      .we_tdr_i  (we_tdr),
      .we_tcr_i  (we_tcr),
      .we_tsr_i  (we_tsr),
      .wdata_i   (pwdata),
      .reg_sel_i (reg_sel),
      .rdata_o   (ch_rdata[i]),
      .irq_o     (irq[i])
    );
  end

endmodule

// File: tb/tb_apb_timer_mc.sv
// Self-checking bench for apb_timer_mc (NUM_CH = 4, CNT_W = 8) against a
// cycle-level behavioural model of the register/timer rules.
module tb_apb_timer_mc;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic [3:0] irq;

  always #5 pclk = ~pclk;

  apb_timer_mc #(
    .NUM_CH(4),
    .CNT_W (8)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .irq     (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state (value held before the next rising edge)
  int m_tdr [4];
  int m_tcr [4];
  int m_tcnt[4];
  int m_ovf [4];
  int m_udf [4];
  int m_irq [4];
  int m_presc;
  bit m_rst;
  bit m_commit;
  bit m_write;
  int m_addr;
  int m_wdata;
  int m_rdata;
  bit m_err;

  function automatic int reg_val(input int addr);
    int c = addr >> 2;
    if (c >= 4) return 0;
    case (addr & 3)
      0:       return m_tdr[c];
      1:       return m_tcr[c];
      2:       return m_ovf[c] + 2 * m_udf[c];
      default: return m_tcnt[c];
    endcase
  endfunction

  function automatic bit err_of(input int addr, input bit wr);
`ifdef APB_TIMER_MC_PSLVERR_EN
    return ((addr >> 2) >= 4) || (wr && ((addr & 3) == 3));
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    int  c, r, div;
    bit  wr_ok, tick, ld, set_o, set_u, clr;
    if (m_rst) begin
      for (int i = 0; i < 4; i++) begin
        m_tdr[i] = 0; m_tcr[i] = 0; m_tcnt[i] = 0;
        m_ovf[i] = 0; m_udf[i] = 0; m_irq[i] = 0;
      end
      m_presc = 0;
      return;
    end
    c = m_addr >> 2;
    r = m_addr & 3;
    wr_ok = 1'b0;
    if (m_commit) begin
      m_err = err_of(m_addr, m_write);
      if (!m_write) m_rdata = m_err ? 0 : reg_val(m_addr);
      wr_ok = m_write && !m_err && (c < 4);
    end
    for (int i = 0; i < 4; i++) begin
      m_irq[i] = ((m_ovf[i] != 0) && ((m_tcr[i] & 'h10) != 0)) ||
                 ((m_udf[i] != 0) && ((m_tcr[i] & 'h20) != 0));
      div   = 2 << ((m_tcr[i] >> 2) & 3);
      tick  = (m_presc % div) == (div - 1);
      ld    = wr_ok && (c == i) && (r == 1) && ((m_wdata & 'h80) != 0);
      clr   = wr_ok && (c == i) && (r == 2);
      set_o = 1'b0;
      set_u = 1'b0;
      if (ld) begin
        m_tcnt[i] = m_tdr[i];
      end else if (((m_tcr[i] & 1) != 0) && tick) begin
        if ((m_tcr[i] & 2) == 0) begin
          if (m_tcnt[i] == 255) begin m_tcnt[i] = m_tdr[i]; set_o = 1'b1; end
          else m_tcnt[i] = m_tcnt[i] + 1;
        end else begin
          if (m_tcnt[i] == 0) begin m_tcnt[i] = m_tdr[i]; set_u = 1'b1; end
          else m_tcnt[i] = m_tcnt[i] - 1;
        end
      end
      m_ovf[i] = (set_o || ((m_ovf[i] != 0) && !(clr && ((m_wdata & 1) != 0)))) ? 1 : 0;
      m_udf[i] = (set_u || ((m_udf[i] != 0) && !(clr && ((m_wdata & 2) != 0)))) ? 1 : 0;
      if (wr_ok && (c == i) && (r == 0)) m_tdr[i] = m_wdata & 'hFF;
      if (wr_ok && (c == i) && (r == 1)) m_tcr[i] = m_wdata & 'h3F;
    end
    m_presc = (m_presc + 1) % 16;
  endtask

  task automatic cycle();
    logic [3:0] exp_irq;
    @(posedge pclk);
    model_edge();
    @(negedge pclk);
    for (int i = 0; i < 4; i++) exp_irq[i] = (m_irq[i] != 0);
    check_eq("irq", 32'(irq), 32'(exp_irq));
  endtask

  task automatic apb(input bit wr, input int addr, input int wdata, output int rdata);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr[7:0];
    pwdata  = wdata[7:0];
    cycle();
    check_eq("pready_setup", 32'(pready), 0);
    penable  = 1'b1;
    m_commit = 1'b1;
    m_write  = wr;
    m_addr   = addr;
    m_wdata  = wdata;
    cycle();
    m_commit = 1'b0;
    check_eq("pready_hi", 32'(pready), 1);
    check_eq("pslverr", 32'(pslverr), 32'(m_err));
    if (!wr) check_eq("prdata", 32'(prdata), m_rdata);
    rdata   = int'(prdata);
    psel    = 1'b0;
    penable = 1'b0;
    cycle();
    check_eq("pready_lo", 32'(pready), 0);
  endtask

  task automatic wr(input int addr, input int data);
    int dummy;
    apb(1'b1, addr, data, dummy);
  endtask

  task automatic rd(input int addr, output int data);
    apb(1'b0, addr, 0, data);
  endtask

  // Idle until the commit edge of the next transfer sees prescaler == target
  task automatic align_commit(input int target);
    for (int i = 0; i < 16 && ((m_presc + 1) % 16) != target; i++) cycle();
  endtask

  initial begin
    int d, v, a;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    m_commit = 1'b0; m_write = 1'b0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_err = 1'b0;
    presetn = 1'b0;
    m_rst   = 1'b1;
    repeat (3) cycle();
    presetn = 1'b1;
    m_rst   = 1'b0;
    check_eq("rst_prdata", 32'(prdata), 0);
    check_eq("rst_pready", 32'(pready), 0);
    check_eq("rst_pslverr", 32'(pslverr), 0);

    // Every register of every channel reads zero after reset
    for (int i = 0; i < 16; i++) begin
      rd(i, d);
      check_eq("rst_reg", d, 0);
    end

    // TDR and TCR readback; LOAD and reserved bits read 0
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, 3) * 4;
      v = $urandom_range(0, 255);
      wr(a, v);
      rd(a, d);
      check_eq("tdr_rb", d, v);
      v = $urandom_range(0, 255) & 'hFE;
      wr(a + 1, v);
      rd(a + 1, d);
      check_eq("tcr_rb", d, v & 'h3F);
    end
    for (int i = 0; i < 4; i++) begin
      wr(i * 4 + 1, 0);
      wr(i * 4 + 2, 3);
    end

    // ch1: up-count from FD, /2, overflow with interrupt
    wr(8'h04, 8'hFD);
    wr(8'h05, 8'h91);
    for (int i = 0; i < 10; i++) rd(8'h07, d);
    rd(8'h06, d);
    check_eq("ch1_ovf", d & 1, 1);
    check_eq("ch1_irq", 32'(irq[1]), 1);
    wr(8'h05, 8'h10);
    wr(8'h06, 1);
    rd(8'h06, d);
    check_eq("ch1_ovf_clr", d, 0);
    cycle(); cycle();
    check_eq("ch1_irq_clr", 32'(irq[1]), 0);

    // ch2: down-count from 2, /4, underflow reload
    wr(8'h08, 8'h02);
    wr(8'h09, 8'hA7);
    for (int i = 0; i < 12; i++) rd(8'h0B, d);
    rd(8'h0A, d);
    check_eq("ch2_udf", (d >> 1) & 1, 1);
    check_eq("ch2_no_ovf", d & 1, 0);
    wr(8'h09, 8'h00);

    // ch0: W1C coinciding with an overflow keeps the flag set
    wr(8'h00, 8'hFF);
    wr(8'h01, 8'h9D);
    align_commit(15);
    wr(8'h02, 1);
    rd(8'h02, d);
    check_eq("w1c_vs_set", d & 1, 1);
    align_commit(7);
    wr(8'h02, 1);
    rd(8'h02, d);
    check_eq("w1c_plain", d & 1, 0);
    wr(8'h01, 8'h00);
    wr(8'h02, 3);

    // ch3: LOAD on a tick edge wins, no flag
    wr(8'h0C, 8'h40);
    wr(8'h0D, 8'h8D);
    wr(8'h0E, 3);
    align_commit(15);
    wr(8'h0D, 8'h8D);
    rd(8'h0F, d);
    check_eq("load_vs_tick", d, 8'h40);
    rd(8'h0E, d);
    check_eq("load_no_flag", d, 0);
    wr(8'h0D, 8'h00);

    // Absent channel and TCNT write
    rd(8'h10, d);
    check_eq("oor_read", d, 0);
    wr(8'h03, 8'h77);
    rd(8'h03, d);
    wr(8'h20, 8'h99);
    rd(8'h00, d);

    // Random mixed traffic, including absent channels
    for (int i = 0; i < 80; i++) begin
      a = $urandom_range(0, 8'h1F);
      v = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) wr(a, v);
      else rd(a, d);
      repeat ($urandom_range(0, 3)) cycle();
    end

    // Reset in the commit cycle aborts the write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h55;
    cycle();
    penable = 1'b1;
    presetn = 1'b0;
    m_rst   = 1'b1;
    cycle();
    presetn = 1'b1;
    m_rst   = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    check_eq("rst_abort_pready", 32'(pready), 0);
    rd(8'h00, d);
    check_eq("rst_abort_tdr", d, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
